// File: rtl/mem_stage.sv
// Pipeline memory stage. It issues data-memory accesses for loads and stores
// coming from execute, and splits misaligned word and halfword accesses into
// two aligned word accesses. A split stalls upstream for one cycle and inserts
// one bubble. For a split load, the two read words are merged so that
// writeback's usual opcode/address extraction yields the correct value.
module mem_stage #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt,
   input  logic              bubble_in,
   input  logic [4:0]        opcode_in,
   input  logic [4:0]        tgt_in_1,
   input  logic [4:0]        tgt_in_2,
   input  logic              is_load_in,
   input  logic              is_store_in,
   input  logic [31:0]       alu_result_in_1,
   input  logic [31:0]       alu_result_in_2,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [31:0]       store_data_in,
   output logic              stall_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_ren,
   output logic [3:0]        mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              bubble_out,
   output logic [4:0]        opcode_out,
   output logic [4:0]        tgt_out_1,
   output logic [4:0]        tgt_out_2,
   output logic              is_load_out,
   output logic              is_store_out,
   output logic [31:0]       alu_result_out_1,
   output logic [31:0]       alu_result_out_2,
   output logic [ADDR_W-1:0] addr_out,
   output logic [31:0]       mem_result_out
);

   typedef enum logic {IDLE, SPLIT2} state_t;

   state_t            state, state_nx;
   logic              split_flag;
   logic [31:0]       low_buf;

   logic [1:0]        off;
   logic [4:0]        lo_sh;        // 8*off
   logic [5:0]        hi_sh;        // 8*(4-off)
   logic [2:0]        hi_nib;       // 4-off
   logic              is_word, is_half;
   logic              mem_op, split;
   logic [ADDR_W-1:0] word_base;

   logic [1:0]        off_r;
   logic [4:0]        lo_sh_r;
   logic [5:0]        hi_sh_r;
   logic              half_r;

   assign off       = addr_in[1:0];
   assign lo_sh     = {off, 3'b000};
   assign hi_sh     = 6'd32 - {1'b0, lo_sh};
   assign hi_nib    = 3'd4 - {1'b0, off};
   assign is_word   = (opcode_in >= 5'd3) && (opcode_in <= 5'd5);
   assign is_half   = (opcode_in >= 5'd6) && (opcode_in <= 5'd8);
   assign mem_op    = !bubble_in && (is_load_in || is_store_in);
   assign split     = mem_op && ((is_word && off != 2'd0) || (is_half && off == 2'd3));
   assign word_base = {addr_in[ADDR_W-1:2], 2'b00};

   // State register; halt is folded into state_nx.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state, stall and memory strobes. A first access uses the
   // left-shifted enable mask, which for an unsplit op is also the right one,
   // so both IDLE cases share one expression.
   always_comb begin
      state_nx  = state;
      stall_out = 1'b0;
      mem_addr  = word_base;
      mem_ren   = 1'b0;
      mem_we    = 4'b0000;
      mem_wdata = 32'h0;
      case (state)
         IDLE: begin
            stall_out = split;
            if (split) state_nx = SPLIT2;
            if (mem_op) begin
               mem_ren = is_load_in;
               if (is_store_in) begin
                  mem_wdata = store_data_in << lo_sh;
                  if (is_word)      mem_we = 4'b1111 << off;
                  else if (is_half) mem_we = 4'b0011 << off;
                  else              mem_we = 4'b0001 << off;
               end
            end
         end
         SPLIT2: begin
            state_nx = IDLE;
            mem_addr = word_base + ADDR_W'(4);
            mem_ren  = is_load_in;
            if (is_store_in) begin
               if (is_word) begin
                  mem_we    = 4'b1111 >> hi_nib;
                  mem_wdata = store_data_in >> hi_sh;
               end else begin
                  mem_we    = 4'b0001;
                  mem_wdata = store_data_in >> 8;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
      if (halt) begin
         state_nx = state;
         mem_ren  = 1'b0;
         mem_we   = 4'b0000;
      end
      if (rst) begin
         stall_out = 1'b0;
         mem_ren   = 1'b0;
         mem_we    = 4'b0000;
      end
   end

   // Pipeline registers to writeback; the first half of a split becomes a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_out       <= 1'b1;
         opcode_out       <= '0;
         tgt_out_1        <= '0;
         tgt_out_2        <= '0;
         is_load_out      <= 1'b0;
         is_store_out     <= 1'b0;
         alu_result_out_1 <= '0;
         alu_result_out_2 <= '0;
         addr_out         <= '0;
         split_flag       <= 1'b0;
         low_buf          <= '0;
      end else if (!halt) begin
         opcode_out       <= opcode_in;
         is_load_out      <= is_load_in;
         is_store_out     <= is_store_in;
         alu_result_out_1 <= alu_result_in_1;
         alu_result_out_2 <= alu_result_in_2;
         addr_out         <= addr_in;
         if (state == IDLE && split) begin
            bubble_out <= 1'b1;
            tgt_out_1  <= '0;
            tgt_out_2  <= '0;
         end else begin
            bubble_out <= bubble_in;
            tgt_out_1  <= tgt_in_1;
            tgt_out_2  <= tgt_in_2;
            split_flag <= (state == SPLIT2);
         end
         if (state == SPLIT2) low_buf <= mem_rdata;
      end
   end

   assign off_r   = addr_out[1:0];
   assign lo_sh_r = {off_r, 3'b000};
   assign hi_sh_r = 6'd32 - {1'b0, lo_sh_r};
   assign half_r  = (opcode_out >= 5'd6) && (opcode_out <= 5'd8);

   // Load result: raw read word, or the two halves of a split merged so that
   // writeback's normal extraction picks out the right bytes.
   always_comb begin
      mem_result_out = mem_rdata;
      if (split_flag) begin
         if (half_r) mem_result_out = {mem_rdata[7:0], low_buf[31:24], 16'h0000};
         else        mem_result_out = (mem_rdata << hi_sh_r) | (low_buf >> lo_sh_r);
      end
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline memory stage, directly upstream of writeback.
- Issues data-memory reads and writes for load/store instructions from execute.
- Splits misaligned word and halfword accesses into two aligned word accesses, stalling upstream for one cycle, and assembles the load result so writeback's existing opcode/addr extraction yields the correct value.
- Registers all pipeline fields consumed by writeback.

Parameters:
- ADDR_W, 32, data-memory byte-address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- halt  in  1  freeze stage, including state, outputs and memory strobes
- bubble_in  in  1  incoming slot is a bubble
- opcode_in  in  5  3-5 word, 6-8 halfword, 9-11 byte memory ops
- tgt_in_1  in  5  destination 1
- tgt_in_2  in  5  destination 2
- is_load_in  in  1  load
- is_store_in  in  1  store
- alu_result_in_1  in  32  ALU result 1
- alu_result_in_2  in  32  ALU result 2
- addr_in  in  ADDR_W  effective byte address
- store_data_in  in  32  store data, right-justified
- stall_out  out  1  hold execute and earlier stages
- mem_addr  out  ADDR_W  word address; bits [1:0] always 0
- mem_ren  out  1  read strobe
- mem_we  out  4  byte write enables, little-endian
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after mem_ren
- bubble_out  out  1  registered
- opcode_out  out  5  registered
- tgt_out_1  out  5  registered
- tgt_out_2  out  5  registered
- is_load_out  out  1  registered
- is_store_out  out  1  registered
- alu_result_out_1  out  32  registered
- alu_result_out_2  out  32  registered
- addr_out  out  ADDR_W  registered
- mem_result_out  out  32  load data for writeback, combinational

Behaviour:
- Notation: o = addr_in[1:0]; W = {addr_in[31:2], 2'b00}.
- Memory op = !bubble_in && (is_load_in || is_store_in). No strobes are driven otherwise.
- Split condition: word op with o != 0, or halfword op with o == 3. Byte ops never split.
- FSM states: IDLE, SPLIT2.
- IDLE, unsplit op:
  - mem_addr = W.
  - Load: mem_ren = 1.
  - Store: mem_we = (4'b1111 for word | 4'b0011 << o for halfword | 4'b0001 << o for byte); mem_wdata = store_data_in << 8*o.
  - Pipeline registers capture the inputs at the clock edge.
- IDLE, split op:
  - Issue first access at W: load via mem_ren; store with mem_we = 4'b1111 << o masked to 4 bits, mem_wdata = store_data_in << 8*o.
  - stall_out = 1. Pipeline registers load bubble_out = 1, tgt_out_1 = 0, tgt_out_2 = 0. Next state SPLIT2.
- SPLIT2:
  - Inputs are held by the stall. Issue second access at W + 4.
  - Word store: mem_we = 4'b1111 >> (4 - o); mem_wdata = store_data_in >> 8*(4 - o).
  - Halfword store (o == 3): mem_we = 4'b0001; mem_wdata = store_data_in >> 8.
  - Loads: capture mem_rdata (first word) into low_buf.
  - stall_out = 0. Pipeline registers capture the instruction. Set split_flag register. Next state IDLE.
- mem_result_out:
  - split_flag = 0: mem_rdata.
  - Split word: (mem_rdata << 8*(4 - o)) | (low_buf >> 8*o).
  - Split halfword: {mem_rdata[7:0], low_buf[31:24], 16'h0000}. Writeback's >>16 then yields the halfword.
  - split_flag clears on any unsplit capture.
- halt = 1:
  - No register or state change.
  - mem_ren = 0, mem_we = 0.
  - stall_out passes through its current state value.
- Reset (async, any state, including mid-split):
  - State IDLE; split_flag = 0; low_buf = 0.
  - bubble_out = 1; all other registered outputs 0.
  - stall_out = 0; strobes 0.
  - A partially completed split store leaves its first write in memory; this is not undone.
- Latency: 1 cycle aligned, 2 cycles split. Exactly one bubble is inserted per split.

Test Plan:
- Aligned lw, addr 0x100, RAM[0x100] = 0xDEADBEEF -> one read at 0x100; stall_out never 1; mem_result_out = 0xDEADBEEF.
- Word load, addr 0x101, RAM[0x100] = 0x44332211, RAM[0x104] = 0x88776655 -> reads 0x100 then 0x104; one bubble; mem_result_out = 0x55443322.
- Word store 0xAABBCCDD at 0x102 -> write 0x100 we = 1100 wdata = 0xCCDD0000; then 0x104 we = 0011 wdata = 0x0000AABB.
- Halfword store 0x1234 at 0x103 -> 0x100 we = 1000 byte 0x34; 0x104 we = 0001 byte 0x12. Halfword load from the same address -> writeback value 0x1234.
- Split load with halt asserted 3 cycles in SPLIT2 -> strobes 0 and registers frozen during halt; completes correctly after release.
- rst asserted in SPLIT2 -> immediately IDLE, bubble_out = 1, stall_out = 0, no further strobes.
